pipe_id_ex_skid: RTL and testbench

Parametrised ID/EX pipeline stage register, the successor to the fixed 8-bit stall/bubble register. It uses a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush that inserts a NOP bubble. It sits between the decode/register-read stage and the ALU/EX stage. A saturating bubble counter supports hazard and performance analysis.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_id_ex_skid.sv | 119 +++++++++++
 tb/tb_pipe_id_ex_skid.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the pipeline stage registers.
// The state value doubles as the entry count held by a 2-entry skid stage.
package pipe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;
  localparam int RD_W_DEF   = 3;
  localparam int CNT_W_DEF  = 16;

  localparam int OPC_NOP = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with an asynchronous active-low clear.
// It stops at all-ones and only the clear brings it back to zero.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID/EX stage register with a 2-entry skid buffer, flush-to-bubble and a
// saturating count of cycles in which no instruction is presented to EX.
module pipe_id_ex_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  opcode_out,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out,
  output logic [RD_W-1:0]   rd_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PAY_W = OPC_W + 2 * DATA_W + RD_W;
  localparam logic [PAY_W-1:0] NOP_PAY = {OPC_W'(OPC_NOP), {(PAY_W - OPC_W){1'b0}}};

  pipe_state_e      state_reg, state_next;
  logic [PAY_W-1:0] main_reg, main_next;
  logic [PAY_W-1:0] skid_reg, skid_next;
  logic             in_ready_reg, in_ready_next;
  logic [PAY_W-1:0] in_pay;
  logic             accept, fire;

  assign in_pay = {opcode_in, A_in, B_in, rd_in};
  assign accept = in_valid & in_ready_reg;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // A fire in this cycle already delivered; anything offered is dropped.
      state_next = EMPTY;
      main_next  = NOP_PAY;
      skid_next  = NOP_PAY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = in_pay;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_next = in_pay;
          end else if (accept) begin
            state_next = FULL;
            skid_next  = in_pay;
          end else if (fire) begin
            state_next = EMPTY;
            main_next  = NOP_PAY;
          end
        end
        FULL: begin
          if (fire) begin
            state_next = ONE;
            main_next  = skid_reg;
            skid_next  = NOP_PAY;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = NOP_PAY;
          skid_next  = NOP_PAY;
        end
      endcase
    end
  end

  // Registered ready looks one state ahead so it never depends on out_ready.
  assign in_ready_next = (state_next != FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= EMPTY;
      main_reg     <= NOP_PAY;
      skid_reg     <= NOP_PAY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign occupancy = state_reg;
  assign {opcode_out, A_out, B_out, rd_out} = main_reg;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .clr_n(rstn),
    .inc  (~out_valid),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_id_ex_skid.sv
// Randomised and directed bench for pipe_id_ex_skid, checked against a
// queue-based model of a 2-deep in-order buffer with flush and bubble counting.
module tb_pipe_id_ex_skid;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       in_valid, flush, out_ready;
  logic [3:0] opcode_in;
  logic [7:0] A_in, B_in;
  logic [2:0] rd_in;

  logic        in_ready, out_valid;
  logic [3:0]  opcode_out;
  logic [7:0]  A_out, B_out;
  logic [2:0]  rd_out;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic       in_ready4, out_valid4;
  logic [3:0] opcode_out4;
  logic [7:0] A_out4, B_out4;
  logic [2:0] rd_out4;
  logic [1:0] occupancy4;
  logic [3:0] bubble_cnt4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
  } pay_t;

  pay_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned bub_model = 0;
  int unsigned bub4_model = 0;
  bit          ff_seen = 1'b0;

  always #5 clk = ~clk;

  pipe_id_ex_skid dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(opcode_in), .A_in(A_in), .B_in(B_in), .rd_in(rd_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(opcode_out), .A_out(A_out), .B_out(B_out), .rd_out(rd_out),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_id_ex_skid #(.CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(1'b0), .in_ready(in_ready4),
    .opcode_in(4'h0), .A_in(8'h00), .B_in(8'h00), .rd_in(3'h0),
    .flush(1'b0), .out_valid(out_valid4), .out_ready(1'b0),
    .opcode_out(opcode_out4), .A_out(A_out4), .B_out(B_out4), .rd_out(rd_out4),
    .occupancy(occupancy4), .bubble_cnt(bubble_cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd);
    in_valid  = v;
    opcode_in = op;
    A_in      = a;
    B_in      = b;
    rd_in     = rd;
  endtask

  // Monitor: sample between edges, compare against the model, then advance it.
  always @(negedge clk) begin : mon
    int   n;
    bit   fire_m, acc_m;
    pay_t cur;
    if (!rstn) begin
      exp_q.delete();
      bub_model  = 0;
      bub4_model = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_bubble", bubble_cnt, 0);
      chk("rst_A_out", A_out, 0);
    end else begin
      n = exp_q.size();
      chk("occupancy", occupancy, n);
      chk("out_valid", out_valid, n > 0);
      chk("in_ready", in_ready, n < 2);
      chk("bubble_cnt", bubble_cnt, bub_model);
      chk("bubble_cnt4", bubble_cnt4, bub4_model);
      if (n > 0) begin
        chk("opcode_out", opcode_out, exp_q[0].op);
        chk("A_out", A_out, exp_q[0].a);
        chk("B_out", B_out, exp_q[0].b);
        chk("rd_out", rd_out, exp_q[0].rd);
      end else begin
        chk("idle_payload", {opcode_out, A_out, B_out, rd_out}, 0);
      end
      fire_m = (n > 0) && out_ready;
      acc_m  = in_valid && (n < 2);
      if (fire_m) begin
        $display("TXN t=%0t op=%h A=%h B=%h rd=%h flush=%0d", $time,
                 opcode_out, A_out, B_out, rd_out, flush);
        if (A_out == 8'hFF) ff_seen = 1'b1;
      end
      if (n == 0 && bub_model != 32'd65535) bub_model++;
      if (bub4_model != 32'd15) bub4_model++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (fire_m) void'(exp_q.pop_front());
        if (acc_m) begin
          cur = '{opcode_in, A_in, B_in, rd_in};
          exp_q.push_back(cur);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    flush     = 1'b0;
    out_ready = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Idle after reset release
    repeat (5) @(posedge clk);
    #1;
    chk("idle5_bubble", bubble_cnt, 5);
    chk("idle5_out_valid", out_valid, 0);
    chk("idle5_opcode", opcode_out, 0);
    chk("idle5_in_ready", in_ready, 1);

    // Back-to-back stream with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h3, 8'(8'h11 + i), 8'h22, 3'(1 + i));
      tick();
      chk("stream_A", A_out, 8'(8'h11 + i));
      chk("stream_occ", occupancy, 1);
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    repeat (2) tick();

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 4'h5, 8'hA1, 8'h33, 3'd2);
    tick();
    drive(1'b1, 4'h6, 8'hA2, 8'h44, 3'd3);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    tick();
    chk("skid_occ", occupancy, 2);
    chk("skid_in_ready", in_ready, 0);
    chk("skid_A_hold", A_out, 8'hA1);
    out_ready = 1'b1;
    tick();
    chk("skid_drain_A2", A_out, 8'hA2);
    chk("skid_drain_occ", occupancy, 1);
    tick();
    chk("skid_drained", out_valid, 0);

    // Flush while full, with an instruction offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 4'h7, 8'hB1, 8'h55, 3'd4);
    tick();
    drive(1'b1, 4'h8, 8'hB2, 8'h66, 3'd5);
    tick();
    drive(1'b1, 4'h9, 8'hFF, 8'h77, 3'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_payload", {opcode_out, A_out, B_out, rd_out}, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 8'hC1, 8'h12, 3'd1);
    tick();
    drive(1'b1, 4'h2, 8'hC2, 8'h13, 3'd2);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    chk("pre_rst_occ", occupancy, 2);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_A", A_out, 0);
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'h4, 8'h5A, 8'h21, 3'd7);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_A", A_out, 8'h5A);

    // Randomised traffic, back-pressure and occasional flushes
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 254)), 8'($urandom_range(0, 255)),
            3'($urandom_range(0, 7)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'h0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();

    chk("bubble4_saturated", bubble_cnt4, 4'hF);
    chk("ff_never_output", ff_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
